segasys1_sprcoll_ctrl: RTL and testbench

//  Owns the 1024x1 sprite-sprite collision RAM and shares it between the sprite renderer and the Z80.

---
 rtl/segasys1_pkg.sv | 24 ++
 rtl/segasys1_evt_fifo.sv | 45 ++++
 rtl/segasys1_sprcoll_ctrl.sv | 125 ++++++++++++
 tb/tb_segasys1_sprcoll_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segasys1_pkg.sv
// Shared definitions for the System 1 sprite-collision controller:
// FSM encoding, default RAM address width and the CPU summary register layout.
package segasys1_pkg;

  localparam int unsigned AW_DEF      = 10;
  localparam int unsigned SUM_ANY_BIT = 0;
  localparam int unsigned SUM_OVF_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SPR_WR,
    ST_CPU_RDD,
    ST_DONE
  } state_t;

  function automatic logic [7:0] summary_byte(input logic ovf, input logic any);
    logic [7:0] b;
    b              = '0;
    b[SUM_OVF_BIT] = ovf;
    b[SUM_ANY_BIT] = any;
    return b;
  endfunction

endpackage

// File: rtl/segasys1_evt_fifo.sv
// Small synchronous FIFO for queued collision addresses.
// Full/empty are told apart by one extra pointer bit.
module segasys1_evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/segasys1_sprcoll_ctrl.sv
// Sprite-sprite collision RAM shared between the renderer (queued set-bit writes)
// and the Z80 (wait-stated read / clear port), with sticky summary flags.
module segasys1_sprcoll_ctrl
  import segasys1_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AW         = AW_DEF
) (
  input  logic          VCLKx8,
  input  logic          RESET,
  input  logic          VCLKx4_EN,
  input  logic          sprcoll,
  input  logic [AW-1:0] sprcoll_ad,
  input  logic          cpu_cs,
  input  logic          cpu_wr,
  input  logic          cpu_sum,
  input  logic [AW-1:0] cpu_ad,
  output logic [7:0]    cpu_dout,
  output logic          cpu_rdy,
  output logic          coll_any,
  output logic          evt_ovf
);

  state_t        state;
  logic [1:0]    starve_cnt;
  logic          capture;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW-1:0] fifo_head;
  logic          cpu_req;
  logic          cpu_starve;
  logic          cpu_grant;
  logic          ram_we;
  logic          ram_wd;
  logic [AW-1:0] ram_addr;
  logic          ram_q;
  logic          ram [2**AW];

  assign capture    = VCLKx4_EN & sprcoll;
  assign cpu_req    = cpu_cs & ~cpu_rdy;
  assign cpu_starve = (starve_cnt == 2'd2);
  assign cpu_grant  = (state == ST_IDLE) & cpu_req & (fifo_empty | cpu_starve);

  segasys1_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (AW)
  ) u_fifo (
    .clk   (VCLKx8),
    .rst   (RESET),
    .push  (capture),
    .pop   (state == ST_SPR_WR),
    .din   (sprcoll_ad),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Gating with RESET keeps an access interrupted by reset from landing in the RAM.
  always_comb begin
    ram_we   = 1'b0;
    ram_wd   = 1'b0;
    ram_addr = cpu_ad;
    if (state == ST_SPR_WR) begin
      ram_we   = ~RESET;
      ram_wd   = 1'b1;
      ram_addr = fifo_head;
    end else if (cpu_grant & cpu_wr & ~cpu_sum) begin
      ram_we = ~RESET;
    end
  end

  always_ff @(posedge VCLKx8) begin
    if (ram_we) ram[ram_addr] <= ram_wd;
    ram_q <= ram[ram_addr];
  end

  always_ff @(posedge VCLKx8 or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      cpu_dout   <= '0;
      cpu_rdy    <= 1'b0;
      coll_any   <= 1'b0;
      evt_ovf    <= 1'b0;
    end else begin
      cpu_rdy <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_grant) begin
            starve_cnt <= '0;
            if (cpu_sum & ~cpu_wr) cpu_dout <= summary_byte(evt_ovf, coll_any);
            if (~cpu_sum & ~cpu_wr) begin
              state <= ST_CPU_RDD;
            end else begin
              state   <= ST_DONE;
              cpu_rdy <= 1'b1;
            end
          end else if (~fifo_empty) begin
            state      <= ST_SPR_WR;
            starve_cnt <= cpu_req ? starve_cnt + 2'd1 : 2'd0;
          end else if (~cpu_req) begin
            starve_cnt <= '0;
          end
        end
        ST_SPR_WR: state <= ST_IDLE;
        ST_CPU_RDD: begin
          cpu_dout <= {7'b0, ram_q};
          cpu_rdy  <= 1'b1;
          state    <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      // A capture in the same cycle as a summary clear must win.
      if (cpu_grant & cpu_sum & cpu_wr) begin
        coll_any <= 1'b0;
        evt_ovf  <= 1'b0;
      end
      if (capture) coll_any <= 1'b1;
      if (capture & fifo_full) evt_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_segasys1_sprcoll_ctrl.sv
// Bench for segasys1_sprcoll_ctrl: directed scenarios plus a randomized run
// checked against a bit-array / flag model of the collision RAM.
module tb_segasys1_sprcoll_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       spr;
  logic [9:0] spr_ad;
  logic       cs;
  logic       wr;
  logic       sum;
  logic [9:0] cpu_ad;
  logic [7:0] dout;
  logic       rdy;
  logic       any;
  logic       ovf;

  int n_vec = 0;
  int n_err = 0;

  bit model_ram [1024];
  bit m_any;
  bit m_ovf;

  logic [7:0] d;
  int         cyc;

  always #5 clk = ~clk;

  segasys1_sprcoll_ctrl #(
    .FIFO_DEPTH (4),
    .AW         (10)
  ) dut (
    .VCLKx8     (clk),
    .RESET      (rst),
    .VCLKx4_EN  (en),
    .sprcoll    (spr),
    .sprcoll_ad (spr_ad),
    .cpu_cs     (cs),
    .cpu_wr     (wr),
    .cpu_sum    (sum),
    .cpu_ad     (cpu_ad),
    .cpu_dout   (dout),
    .cpu_rdy    (rdy),
    .coll_any   (any),
    .evt_ovf    (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spr_evt(input logic [9:0] a);
    en     = 1'b1;
    spr    = 1'b1;
    spr_ad = a;
    tick();
    spr = 1'b0;
    en  = 1'b0;
  endtask

  task automatic cpu_op(input logic w, input logic s, input logic [9:0] a,
                        output logic [7:0] rd, output int n);
    cs     = 1'b1;
    wr     = w;
    sum    = s;
    cpu_ad = a;
    n      = 0;
    rd     = '0;
    forever begin
      tick();
      n++;
      if (rdy) begin
        rd = dout;
        break;
      end
      if (n >= 40) begin
        check("cpu_timeout", n, 0);
        break;
      end
    end
    cs = 1'b0;
  endtask

  function automatic logic [7:0] exp_sum();
    return {6'b0, m_ovf, m_any};
  endfunction

  function automatic logic [9:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return 10'($urandom_range(0, 1023));
    return {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
  endfunction

  initial begin
    logic [9:0] a;
    int         op;
    rst = 1'b1; en = 1'b0; spr = 1'b0; spr_ad = '0;
    cs = 1'b0; wr = 1'b0; sum = 1'b0; cpu_ad = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_dout", dout, 0);
    check("rst_rdy", rdy, 0);
    check("rst_any", any, 0);
    check("rst_ovf", ovf, 0);

    for (int i = 0; i < 1024; i++) begin
      cpu_op(1'b1, 1'b0, 10'(i), d, cyc);
      model_ram[i] = 1'b0;
    end
    m_any = 1'b0; m_ovf = 1'b0;
    tick();

    // 1: single event then read back
    spr_evt(10'h2A5);
    model_ram[10'h2A5] = 1'b1; m_any = 1'b1;
    check("t1_any", any, 1);
    cpu_op(1'b0, 1'b0, 10'h2A5, d, cyc);
    check("t1_read", d, 8'h01);
    cpu_op(1'b0, 1'b1, 10'h000, d, cyc);
    check("t1_sum", d, exp_sum());

    // 2: ten back-to-back captures cannot all fit (at most one drain per two cycles)
    tick();
    en = 1'b1; spr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      spr_ad = 10'h100 + 10'(i);
      tick();
    end
    en = 1'b0; spr = 1'b0;
    m_any = 1'b1; m_ovf = 1'b1;
    check("t2_ovf", ovf, 1);
    repeat (12) tick();
    cpu_op(1'b0, 1'b1, 10'h000, d, cyc);
    check("t2_sum_rd", d, 8'h03);
    cpu_op(1'b1, 1'b1, 10'h000, d, cyc);
    m_any = 1'b0; m_ovf = 1'b0;
    cpu_op(1'b0, 1'b1, 10'h000, d, cyc);
    check("t2_sum_clr", d, 8'h00);
    check("t2_ovf_clr", ovf, 0);
    for (int i = 0; i < 10; i++) begin
      cpu_op(1'b1, 1'b0, 10'h100 + 10'(i), d, cyc);
      model_ram[10'h100 + i] = 1'b0;
    end
    tick();

    // 3: CPU read waiting behind a continuous event stream
    fork
      begin
        en = 1'b1; spr = 1'b1;
        for (int i = 0; i < 8; i++) begin
          spr_ad = 10'h200 + 10'(i);
          tick();
        end
        en = 1'b0; spr = 1'b0;
      end
      begin
        tick(); tick();
        cpu_op(1'b0, 1'b0, 10'h3F0, d, cyc);
      end
    join
    check("t3_latency_bound", (cyc <= 8), 1);
    check("t3_read", d, 8'h00);
    repeat (20) tick();
    for (int i = 0; i < 4; i++) begin
      cpu_op(1'b0, 1'b0, 10'h200 + 10'(i), d, cyc);
      check("t3_drained", d, 8'h01);
    end
    for (int i = 0; i < 8; i++) begin
      cpu_op(1'b1, 1'b0, 10'h200 + 10'(i), d, cyc);
      model_ram[10'h200 + i] = 1'b0;
    end
    cpu_op(1'b1, 1'b1, 10'h000, d, cyc);
    m_any = 1'b0; m_ovf = 1'b0;
    tick();

    // 4: set-then-clear and clear-then-set on one address
    spr_evt(10'h011);
    cpu_op(1'b1, 1'b0, 10'h011, d, cyc);
    cpu_op(1'b0, 1'b0, 10'h011, d, cyc);
    check("t4_set_clr", d, 8'h00);
    cpu_op(1'b1, 1'b0, 10'h011, d, cyc);
    spr_evt(10'h011);
    cpu_op(1'b0, 1'b0, 10'h011, d, cyc);
    check("t4_clr_set", d, 8'h01);
    model_ram[10'h011] = 1'b1; m_any = 1'b1;
    tick();

    // 5: capture in the same cycle as a summary clear
    en = 1'b1; spr = 1'b1; spr_ad = 10'h0F0;
    cs = 1'b1; wr = 1'b1; sum = 1'b1;
    tick();
    en = 1'b0; spr = 1'b0;
    check("t5_rdy", rdy, 1);
    cs = 1'b0;
    model_ram[10'h0F0] = 1'b1; m_any = 1'b1; m_ovf = 1'b0;
    check("t5_any", any, 1);
    check("t5_ovf", ovf, 0);
    tick(); tick();

    // 6: reset during a RAM read, with an event still queued
    en = 1'b1; spr = 1'b1; spr_ad = 10'h0AA;
    cs = 1'b1; wr = 1'b0; sum = 1'b0; cpu_ad = 10'h2A5;
    tick();
    en = 1'b0; spr = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_rdy", rdy, 0);
    check("t6_dout", dout, 0);
    check("t6_any", any, 0);
    check("t6_ovf", ovf, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_rdy_hold", rdy, 0);
    end
    cs = 1'b0;
    rst = 1'b0;
    m_any = 1'b0; m_ovf = 1'b0;
    tick();
    check("t6_rdy_after", rdy, 0);
    cpu_op(1'b0, 1'b0, 10'h2A5, d, cyc);
    check("t6_fresh_lat", cyc, 2);
    check("t6_fresh_rd", d, 8'h01);
    cpu_op(1'b0, 1'b0, 10'h0AA, d, cyc);
    check("t6_flushed", d, 8'h00);
    check("t6_any_after", any, 0);

    // randomized traffic against the model
    for (int r = 0; r < 300; r++) begin
      tick();
      op = $urandom_range(0, 5);
      a  = pick_addr();
      case (op)
        0: begin
          spr_evt(a);
          model_ram[a] = 1'b1; m_any = 1'b1;
          check("r_any_set", any, m_any);
          tick(); tick();
        end
        1: begin
          en = 1'b0; spr = 1'b1; spr_ad = a;
          tick();
          spr = 1'b0;
          check("r_unqual", any, m_any);
        end
        2: begin
          cpu_op(1'b1, 1'b0, a, d, cyc);
          model_ram[a] = 1'b0;
          check("r_wr_lat", cyc, 1);
        end
        3: begin
          cpu_op(1'b0, 1'b0, a, d, cyc);
          check("r_rd", d, {7'b0, model_ram[a]});
          check("r_rd_lat", cyc, 2);
        end
        4: begin
          cpu_op(1'b0, 1'b1, a, d, cyc);
          check("r_sum", d, exp_sum());
        end
        default: begin
          cpu_op(1'b1, 1'b1, a, d, cyc);
          m_any = 1'b0; m_ovf = 1'b0;
          check("r_sum_clr", any, 0);
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
